ws2812_status_color: RTL

- Upstream colour source for the single-LED WS2812 driver.
- Turns the machine status inputs (power LED, floppy activity, hard-disk activity, OSD open) into one 24-bit colour, with activity pulse stretching and timed brightness fades.
- `color_out` connects directly to the driver's `color` input. The driver resends only when the value changes, so the output must stay stable between real changes.

---
 rtl/ws2812_status_color.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ws2812_status_color.sv
// Status-to-colour source for the single-LED WS2812 driver: priority colour select,
// activity pulse stretching, timed brightness fades and a two-stage scaling pipeline.
module ws2812_status_color #(
    parameter int unsigned CLK_FRE  = 28_375_160,
    parameter int unsigned HOLD_MS  = 50,
    parameter int unsigned FADE_MS  = 4,
    parameter int unsigned FADE_INC = 8,
    parameter logic [7:0]  BRIGHT   = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        power_led,
    input  logic        fdd_act,
    input  logic        hdd_act,
    input  logic        osd_active,
    output logic [23:0] color_out
);

    localparam int unsigned MS_DIV = (CLK_FRE / 1000 > 0) ? CLK_FRE / 1000 : 1;
    localparam int unsigned MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int unsigned FADE_N = (FADE_MS > 0) ? FADE_MS : 1;
    localparam int unsigned FADE_W = (FADE_N > 1) ? $clog2(FADE_N) : 1;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned LVL_W  = 8;
    localparam int unsigned PROD_W = 17;

    localparam logic [LVL_W-1:0]  LVL_MAX   = 8'd255;
    localparam logic [LVL_W-1:0]  LVL_DIM   = 8'd64;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_MS);
    localparam logic [LVL_W:0]    STEP      = (LVL_W + 1)'(FADE_INC);
    localparam logic [LVL_W:0]    BRIGHT_P1 = (LVL_W + 1)'(BRIGHT) + 9'd1;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_STEADY = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } fade_state_e;

    // (val * mul) >> 8 with a 17-bit intermediate so 255*256 never wraps
    function automatic logic [7:0] scale8(input logic [7:0] val, input logic [8:0] mul);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(val) * PROD_W'(mul);
        return 8'(prod >> 8);
    endfunction

    logic [MS_W-1:0]   ms_cnt_q,   ms_cnt_d;
    logic [FADE_W-1:0] fade_cnt_q, fade_cnt_d;
    logic [HOLD_W-1:0] fdd_hold_q, fdd_hold_d;
    logic [HOLD_W-1:0] hdd_hold_q, hdd_hold_d;
    logic [LVL_W-1:0]  level_q,    level_d;
    fade_state_e       state_q,    state_d;
    rgb_t              s1_q,       s1_d;
    rgb_t              s2_q,       s2_d;

    logic              ms_tick_c;
    logic              fade_tick_c;
    logic              fdd_active_c;
    logic              hdd_active_c;
    logic [LVL_W-1:0]  target_c;
    rgb_t              base_c;
    logic [LVL_W:0]    rise_sum_c;
    logic [LVL_W:0]    fall_dif_c;
    logic [LVL_W:0]    lvl_p1_c;

    // Millisecond and fade-step timebases
    always_comb begin
        ms_tick_c   = (ms_cnt_q == MS_W'(MS_DIV - 1));
        ms_cnt_d    = ms_tick_c ? '0 : ms_cnt_q + MS_W'(1);
        fade_tick_c = ms_tick_c && (fade_cnt_q == FADE_W'(FADE_N - 1));
        fade_cnt_d  = fade_cnt_q;
        if (ms_tick_c) begin
            fade_cnt_d = fade_tick_c ? '0 : fade_cnt_q + FADE_W'(1);
        end
    end

    // Activity stretching: a new pulse always wins over the ms decrement
    always_comb begin
        fdd_hold_d = fdd_hold_q;
        hdd_hold_d = hdd_hold_q;
        if (fdd_act) begin
            fdd_hold_d = HOLD_LOAD;
        end else if (ms_tick_c && (fdd_hold_q != '0)) begin
            fdd_hold_d = fdd_hold_q - HOLD_W'(1);
        end
        if (hdd_act) begin
            hdd_hold_d = HOLD_LOAD;
        end else if (ms_tick_c && (hdd_hold_q != '0)) begin
            hdd_hold_d = hdd_hold_q - HOLD_W'(1);
        end
    end

    // Source priority and target brightness
    always_comb begin
        fdd_active_c = fdd_act || (fdd_hold_q != '0);
        hdd_active_c = hdd_act || (hdd_hold_q != '0);
        base_c       = '{r: 8'h00, g: 8'h00, b: 8'h00};
        if (osd_active) begin
            base_c = '{r: 8'h00, g: 8'h00, b: 8'hFF};
        end else if (hdd_active_c) begin
            base_c = '{r: 8'hFF, g: 8'h00, b: 8'h00};
        end else if (fdd_active_c) begin
            base_c = '{r: 8'h00, g: 8'hFF, b: 8'h00};
        end else begin
            base_c = '{r: 8'hFF, g: 8'h60, b: 8'h00};
        end
        target_c = (osd_active || fdd_active_c || hdd_active_c || power_led) ? LVL_MAX : LVL_DIM;
    end

    // Fade FSM: direction decided every cycle, level moves only on fade_tick
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        rise_sum_c = (LVL_W + 1)'(level_q) + STEP;
        fall_dif_c = (LVL_W + 1)'(level_q) - STEP;
        case (state_q)
            ST_STEADY: begin
                if (level_q < target_c) begin
                    state_d = ST_RISE;
                end else if (level_q > target_c) begin
                    state_d = ST_FALL;
                end
            end
            ST_RISE: begin
                if (level_q > target_c) begin
                    state_d = ST_FALL;
                end else if (level_q == target_c) begin
                    state_d = ST_STEADY;
                end else if (fade_tick_c) begin
                    level_d = (rise_sum_c >= (LVL_W + 1)'(target_c)) ? target_c
                                                                      : rise_sum_c[LVL_W-1:0];
                end
            end
            ST_FALL: begin
                if (level_q < target_c) begin
                    state_d = ST_RISE;
                end else if (level_q == target_c) begin
                    state_d = ST_STEADY;
                end else if (fade_tick_c) begin
                    // bit 8 set means the subtraction went below zero
                    level_d = (fall_dif_c[LVL_W] || (fall_dif_c[LVL_W-1:0] <= target_c))
                              ? target_c : fall_dif_c[LVL_W-1:0];
                end
            end
            default: begin
                state_d = ST_STEADY;
            end
        endcase
    end

    // Two-stage scaling: fade level first, then global brightness
    always_comb begin
        lvl_p1_c = (LVL_W + 1)'(level_q) + 9'd1;
        s1_d.r   = scale8(base_c.r, lvl_p1_c);
        s1_d.g   = scale8(base_c.g, lvl_p1_c);
        s1_d.b   = scale8(base_c.b, lvl_p1_c);
        s2_d.r   = scale8(s1_q.r, BRIGHT_P1);
        s2_d.g   = scale8(s1_q.g, BRIGHT_P1);
        s2_d.b   = scale8(s1_q.b, BRIGHT_P1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_cnt_q   <= '0;
            fade_cnt_q <= '0;
            fdd_hold_q <= '0;
            hdd_hold_q <= '0;
            level_q    <= '0;
            state_q    <= ST_STEADY;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            ms_cnt_q   <= ms_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            fdd_hold_q <= fdd_hold_d;
            hdd_hold_q <= hdd_hold_d;
            level_q    <= level_d;
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    // GRB word, MSB first on the wire, so bit 0 carries G[7]
    always_comb begin
        color_out = {<<{s2_q.g, s2_q.r, s2_q.b}};
    end

endmodule
